// File: rtl/sonic_echo_emulator.sv
// sonic_echo_emulator: HC-SR04 sensor-side responder for the ultrasonic trig/echo link.
// Latency: trig pin fall -> first echo high cycle = BURST_CYC+3 clk (2 sync + 1 decision).
// Backpressure: none; trig activity outside IDLE/TRIG_HI is ignored, no flow control.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   trig         trigger pulse from the ranging master (asynchronous, synchronized here)
//   distance_cm  emulated obstacle distance, latched once per measurement at trig fall
//   echo         registered echo pulse, width = distance_cm * CYC_PER_CM (or TIMEOUT_CYC)
//   busy         high whenever a measurement is in progress (FSM not IDLE)
//   trig_err     one-cycle pulse when a too-short trig pulse is rejected

module sonic_echo_emulator #(
    parameter int TRIG_MIN_CYC = 1000,
    parameter int BURST_CYC    = 20000,
    parameter int CYC_PER_CM   = 5800,
    parameter int MAX_CM       = 400,
    parameter int TIMEOUT_CYC  = 3800000,
    parameter int HOLDOFF_CYC  = 6000000,
    parameter int CNT_W        = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_TRIG_MIN = CNT_W'(TRIG_MIN_CYC);
    localparam logic [CNT_W-1:0] LP_BURST    = CNT_W'(BURST_CYC);
    localparam logic [CNT_W-1:0] LP_HOLDOFF  = CNT_W'(HOLDOFF_CYC);
    localparam logic [CNT_W-1:0] LP_TIMEOUT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LP_CPC      = CNT_W'(CYC_PER_CM);
    localparam logic [CNT_W-1:0] LP_MAX_CM   = CNT_W'(MAX_CM);

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_trig_m;      // first synchronizer stage (may be metastable)
    logic             r_trig_s;      // synchronized trig
    logic             r_trig_d;      // one-cycle-delayed copy for edge detection
    logic             w_trig_rise;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [8:0]       r_d_lat;
    logic [8:0]       w_d_lat_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_calc;

    logic             r_echo;
    logic             r_busy;
    logic             r_trig_err;
    logic             w_echo_nxt;
    logic             w_busy_nxt;
    logic             w_err_nxt;

    // ------------------------------------------------------------------
    // trig synchronizer and edge detector. The delayed copy keeps running in
    // every state, so a trig already high when IDLE is re-entered shows no
    // edge and cannot start a measurement.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_m <= 1'b0;
            r_trig_s <= 1'b0;
            r_trig_d <= 1'b0;
        end else begin
            r_trig_m <= trig;
            r_trig_s <= r_trig_m;
            r_trig_d <= r_trig_s;
        end
    end

    assign w_trig_rise = r_trig_s & ~r_trig_d;
    assign w_cnt_inc   = r_cnt + LP_ONE;

    // Echo width from the latched distance. Zero or out-of-range distances
    // report "no object". The product is formed at full counter width; the
    // counter width is sized so MAX_CM*CYC_PER_CM never wraps.
    assign w_len_calc = ((r_d_lat == 9'd0) || (CNT_W'(r_d_lat) > LP_MAX_CM))
                        ? LP_TIMEOUT
                        : CNT_W'(r_d_lat) * LP_CPC;

    // ------------------------------------------------------------------
    // State register plus the datapath registers that follow it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_d_lat    <= '0;
            r_len      <= '0;
            r_echo     <= 1'b0;
            r_busy     <= 1'b0;
            r_trig_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_d_lat    <= w_d_lat_nxt;
            r_echo     <= w_echo_nxt;
            r_busy     <= w_busy_nxt;
            r_trig_err <= w_err_nxt;
            // d_lat is frozen for the whole BURST, so the multiplier result
            // registered here is stable by the first ECHO cycle and keeps the
            // multiply out of the ECHO compare path.
            if (r_state == S_BURST) begin
                r_len <= w_len_calc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_d_lat_nxt = r_d_lat;
        w_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_trig_rise) begin
                    w_state_nxt = S_TRIG_HI;
                    w_cnt_nxt   = LP_ONE;   // the edge cycle is the first high cycle
                end
            end

            S_TRIG_HI: begin
                if (r_trig_s) begin
                    // saturate so an arbitrarily long trig cannot wrap the counter
                    if (r_cnt < LP_TRIG_MIN) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (r_cnt >= LP_TRIG_MIN) begin
                    w_state_nxt = S_BURST;
                    w_cnt_nxt   = '0;
                    w_d_lat_nxt = distance_cm;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end
            end

            S_BURST: begin
                if (w_cnt_inc == LP_BURST) begin
                    w_state_nxt = S_ECHO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_ECHO: begin
                if (w_cnt_inc == r_len) begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_HOLDOFF: begin
                if (w_cnt_inc == LP_HOLDOFF) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so each one switches on the
    // same edge as the state it describes and leaves no combinational glitches.
    assign w_echo_nxt = (w_state_nxt == S_ECHO);
    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    assign echo     = r_echo;
    assign busy     = r_busy;
    assign trig_err = r_trig_err;

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Bench for sonic_echo_emulator with shortened timing parameters.
// Reference: accept iff trig high >= TRIG_MIN; echo rises BURST+3 after trig fall,
// lasts len(d) cycles, then HOLDOFF cycles of dead time before busy drops.

module tb_sonic_echo_emulator;

    localparam int TRIG_MIN = 10;
    localparam int BURST    = 20;
    localparam int CPC      = 4;
    localparam int MAXCM    = 400;
    localparam int TMO      = 2000;
    localparam int HOLD     = 50;
    localparam int LAT      = BURST + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       trig_err;

    int n_tests = 0;
    int n_fail  = 0;

    sonic_echo_emulator #(
        .TRIG_MIN_CYC (TRIG_MIN),
        .BURST_CYC    (BURST),
        .CYC_PER_CM   (CPC),
        .MAX_CM       (MAXCM),
        .TIMEOUT_CYC  (TMO),
        .HOLDOFF_CYC  (HOLD),
        .CNT_W        (12)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int model_len(input int d);
        if (d == 0 || d > MAXCM) return TMO;
        return d * CPC;
    endfunction

    function automatic bit model_accept(input int w);
        return w >= TRIG_MIN;
    endfunction

    // One measurement. mode 0: plain; 1: extra trig pulses in ECHO and HOLDOFF;
    // 2: trig raised during HOLDOFF and left high. d1 is applied mid-BURST.
    task automatic run_meas(input int w, input int d0, input int d1, input int mode,
                            output int rise, output int len, output int errs,
                            output int ovl, output int gap);
        int exp_l;
        int fall;
        exp_l = model_len(d0);
        distance_cm = 9'(d0);
        trig = 1'b1;
        repeat (w) tick();
        trig = 1'b0;
        rise = -1; len = 0; errs = 0; ovl = 0; gap = -1; fall = -1;
        for (int t = 1; t <= 2500; t++) begin
            tick();
            if (echo && rise < 0) rise = t;
            if (echo) len++;
            if (trig_err) errs++;
            if (echo && trig_err) ovl++;
            if (rise >= 0 && !echo && fall < 0) fall = t;
            if (fall >= 0 && !busy) begin
                gap = t - fall;
                break;
            end
            if (t == 10) distance_cm = 9'(d1);
            if (mode == 1)
                trig = (t >= 30 && t < 42) || (t >= 33 + exp_l && t < 45 + exp_l);
            if (mode == 2 && t >= 53 + exp_l) trig = 1'b1;
        end
    endtask

    task automatic do_meas(input string tag, input int w, input int d0, input int d1,
                           input int mode);
        int rise, len, errs, ovl, gap;
        run_meas(w, d0, d1, mode, rise, len, errs, ovl, gap);
        check_eq({tag, "_rise"}, rise, LAT);
        check_eq({tag, "_len"}, len, model_len(d0));
        check_eq({tag, "_err"}, errs, 0);
        check_eq({tag, "_ovl"}, ovl, 0);
        check_eq({tag, "_holdoff"}, gap, HOLD);
    endtask

    // Too-short trig: expect a single trig_err 3 cycles after the fall,
    // no echo, and busy low after the error.
    task automatic do_rej(input string tag, input int w);
        int err_at, errs, echos, busy_after;
        distance_cm = 9'($urandom_range(1, 100));
        trig = 1'b1;
        repeat (w) tick();
        trig = 1'b0;
        err_at = -1; errs = 0; echos = 0; busy_after = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (trig_err) begin
                errs++;
                if (err_at < 0) err_at = t;
            end
            if (echo) echos++;
            if (err_at >= 0 && t == err_at + 1) busy_after = int'(busy);
        end
        check_eq({tag, "_errcnt"}, errs, 1);
        check_eq({tag, "_errat"}, err_at, 3);
        check_eq({tag, "_echo"}, echos, 0);
        check_eq({tag, "_busy"}, busy_after, 0);
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1;
        trig = 1'b0;
        distance_cm = '0;
        repeat (3) tick();
        check_eq("rst_echo", echo, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", trig_err, 0);
        rst = 1'b0;
        repeat (2) tick();

        do_meas("basic", 12, 25, 25, 0);
        do_rej("short5", 5);
        do_rej("short9", 9);
        do_meas("min10", 10, 7, 7, 0);
        do_meas("d0", 12, 0, 0, 0);
        do_meas("d401", 12, 401, 401, 0);
        do_meas("d400", 12, 400, 400, 0);
        do_meas("latch", 12, 25, 50, 0);
        do_meas("extra", 12, 25, 25, 1);

        // trig held high across the end of HOLDOFF: no new measurement
        do_meas("hold", 12, 25, 25, 2);
        busy_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (busy || echo) busy_cnt++;
        end
        check_eq("hold_nostart", busy_cnt, 0);
        trig = 1'b0;
        repeat (3) tick();
        do_meas("after_hold", 12, 30, 30, 0);

        // reset 30 cycles into ECHO
        distance_cm = 9'd25;
        trig = 1'b1;
        repeat (12) tick();
        trig = 1'b0;
        repeat (LAT + 30) tick();
        check_eq("pre_rst_echo", echo, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_echo", echo, 0);
        check_eq("mid_rst_busy", busy, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        do_meas("post_rst", 12, 25, 25, 0);

        // randomized runs against the model
        for (int i = 0; i < 6; i++) begin
            int w, d;
            w = int'($urandom_range(1, 16));
            d = int'($urandom_range(0, 511));
            if (model_accept(w)) do_meas("rnd_acc", w, d, int'($urandom_range(0, 511)), 0);
            else do_rej("rnd_rej", w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
